// File: rtl/lc3b_types.sv
// Shared LC-3b types: memory word/cache-block widths and arbiter enums.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_block;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    // Grant id; reset value DCACHE lets the I-cache win the first tie
    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical memory port between the I- and
// D-caches. A granted request is captured and replayed from registers so the
// memory sees stable address/data/op until it responds.
module cache_arbiter
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset_n,

    input  logic        i_pmem_read,
    input  logic        i_pmem_write,
    input  lc3b_word    i_pmem_address,
    input  lc3b_c_block i_pmem_wdata,
    output lc3b_c_block i_pmem_rdata,
    output logic        i_pmem_resp,

    input  logic        d_pmem_read,
    input  logic        d_pmem_write,
    input  lc3b_word    d_pmem_address,
    input  lc3b_c_block d_pmem_wdata,
    output lc3b_c_block d_pmem_rdata,
    output logic        d_pmem_resp,

    output logic        pmem_read,
    output logic        pmem_write,
    output lc3b_word    pmem_address,
    output lc3b_c_block pmem_wdata,
    input  lc3b_c_block pmem_rdata,
    input  logic        pmem_resp
);

    arb_state_t  state_q, state_d;
    arb_grant_t  last_grant_q, last_grant_d;
    lc3b_word    addr_q, addr_d;
    lc3b_c_block wdata_q, wdata_d;
    logic        write_q, write_d;

    logic i_req, d_req;

    assign i_req = i_pmem_read | i_pmem_write;
    assign d_req = d_pmem_read | d_pmem_write;

    // State, round-robin history and captured request registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= DCACHE;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
        end
    end

    // Next-state: grant in IDLE (round-robin on a tie), hold SERVE until resp.
    // Write wins when a client raises read and write together.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        case (state_q)
            IDLE: begin
                if (i_req && !(d_req && last_grant_q == ICACHE)) begin
                    state_d      = SERVE_I;
                    last_grant_d = ICACHE;
                    addr_d       = i_pmem_address;
                    wdata_d      = i_pmem_wdata;
                    write_d      = i_pmem_write;
                end else if (d_req) begin
                    state_d      = SERVE_D;
                    last_grant_d = DCACHE;
                    addr_d       = d_pmem_address;
                    wdata_d      = d_pmem_wdata;
                    write_d      = d_pmem_write;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output mux: memory side from captured registers, response routed
    // straight through to the granted client only
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_rdata = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        case (state_q)
            SERVE_I: begin
                pmem_read    = ~write_q;
                pmem_write   = write_q;
                pmem_address = addr_q;
                pmem_wdata   = wdata_q;
                i_pmem_rdata = pmem_rdata;
                i_pmem_resp  = pmem_resp;
            end
            SERVE_D: begin
                pmem_read    = ~write_q;
                pmem_write   = write_q;
                pmem_address = addr_q;
                pmem_wdata   = wdata_q;
                d_pmem_rdata = pmem_rdata;
                d_pmem_resp  = pmem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: client drivers replay request queues,
// a memory model answers after a fixed delay, and a monitor checks each
// memory transaction against the hand-ordered expected grant list.
module tb_cache_arbiter;
    import lc3b_types::*;

    localparam int LAT = 3;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [127:0] wdata;
        bit          drop;
    } creq_t;

    typedef struct {
        bit          c;
        bit          wr;
        logic [15:0] addr;
        logic [127:0] wdata;
        bit          b2b;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        c_read [2];
    logic        c_write[2];
    lc3b_word    c_addr [2];
    lc3b_c_block c_wdata[2];
    lc3b_c_block i_pmem_rdata, d_pmem_rdata, pmem_wdata, pmem_rdata;
    logic        i_pmem_resp, d_pmem_resp, pmem_read, pmem_write, pmem_resp;
    lc3b_word    pmem_address;
    logic        mem_resp;
    lc3b_c_block mem_rdata;
    logic        stray_resp;

    int checks   = 0;
    int failures = 0;

    creq_t cq0[$];
    creq_t cq1[$];
    exp_t  exp_q[$];
    bit    c_act[2];

    assign pmem_resp  = mem_resp | stray_resp;
    assign pmem_rdata = mem_rdata;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .i_pmem_read(c_read[0]), .i_pmem_write(c_write[0]),
        .i_pmem_address(c_addr[0]), .i_pmem_wdata(c_wdata[0]),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(c_read[1]), .d_pmem_write(c_write[1]),
        .d_pmem_address(c_addr[1]), .d_pmem_wdata(c_wdata[1]),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    function automatic logic [127:0] rdata_for(input logic [15:0] a);
        if (a == 16'h1230) return {16{8'hA5}};
        return {8{a ^ 16'h5A5A}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic push_req(input bit c, input bit rd, input bit wr, input logic [15:0] a,
                            input logic [127:0] wd, input bit drop);
        creq_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.wdata = wd; r.drop = drop;
        if (c) cq1.push_back(r); else cq0.push_back(r);
    endtask

    task automatic exp_push(input bit c, input bit wr, input logic [15:0] a,
                            input logic [127:0] wd, input bit b2b);
        exp_t e;
        e.c = c; e.wr = wr; e.addr = a; e.wdata = wd; e.b2b = b2b;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while ((cq0.size() != 0 || cq1.size() != 0 || c_act[0] || c_act[1] ||
                    exp_q.size() != 0 || pmem_read || pmem_write) && n < 200);
        if (n >= 200) timeout(name);
    endtask

    // Client drivers: sample resp mid-cycle, update requests just after the edge
    initial begin
        creq_t cur[2];
        int    age[2];
        bit    done[2];
        for (int c = 0; c < 2; c++) begin
            c_read[c] = 0; c_write[c] = 0; c_addr[c] = '0; c_wdata[c] = '0;
            c_act[c] = 0; age[c] = 0; done[c] = 0;
        end
        forever begin
            @(negedge clk); #2;
            if (c_act[0] && i_pmem_resp) done[0] = 1;
            if (c_act[1] && d_pmem_resp) done[1] = 1;
            @(posedge clk); #1;
            for (int c = 0; c < 2; c++) begin
                if (!reset_n) begin
                    c_read[c] = 0; c_write[c] = 0; c_act[c] = 0; done[c] = 0;
                end else begin
                    if (done[c]) begin
                        c_read[c] = 0; c_write[c] = 0; c_act[c] = 0; done[c] = 0;
                    end else if (c_act[c]) begin
                        age[c]++;
                        if (cur[c].drop && age[c] == 2) begin
                            c_read[c] = 0; c_write[c] = 0;
                            c_addr[c] = 16'hFFFF; c_wdata[c] = '1;
                        end
                    end
                    if (!c_act[c] && ((c == 0) ? cq0.size() : cq1.size()) != 0) begin
                        cur[c] = (c == 0) ? cq0.pop_front() : cq1.pop_front();
                        c_read[c] = cur[c].rd; c_write[c] = cur[c].wr;
                        c_addr[c] = cur[c].addr; c_wdata[c] = cur[c].wdata;
                        c_act[c] = 1; age[c] = 0;
                    end
                end
            end
        end
    end

    // Memory model: respond in the (LAT+1)th active cycle
    initial begin
        int cnt = 0;
        mem_resp = 0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset_n && (pmem_read || pmem_write) && !mem_resp) begin
                cnt++;
                if (cnt == LAT + 1) begin
                    mem_resp  = 1;
                    mem_rdata = rdata_for(pmem_address);
                end
            end else begin
                mem_resp = 0;
                cnt = 0;
            end
        end
    end

    // Monitor: pop expected grant at each transaction start, check on resp
    initial begin
        exp_t cur;
        bit   in_txn = 0;
        bit   held = 1;
        int   dur = 0;
        int   gap = 0;
        forever begin
            @(negedge clk); #2;
            if (!reset_n) begin
                in_txn = 0;
                gap = 0;
            end else if (pmem_read || pmem_write) begin
                if (!in_txn) begin
                    if (exp_q.size() == 0) begin
                        timeout("unexpected_txn");
                    end else begin
                        cur = exp_q.pop_front();
                        chk("op", {126'd0, pmem_read, pmem_write}, cur.wr ? 128'd1 : 128'd2);
                        chk("address", 128'(pmem_address), 128'(cur.addr));
                        chk("wdata", pmem_wdata, cur.wdata);
                        if (cur.b2b) chk("idle_gap", 128'(gap), 128'd1);
                    end
                    in_txn = 1; dur = 0; held = 1;
                end
                dur++;
                if (pmem_address !== cur.addr || pmem_wdata !== cur.wdata) held = 0;
                if (pmem_resp) begin
                    chk("duration", 128'(dur), 128'(LAT + 1));
                    chk("held", 128'(held), 128'd1);
                    if (!cur.c) begin
                        chk("i_resp", {126'd0, i_pmem_resp, d_pmem_resp}, 128'd2);
                        chk("i_rdata", i_pmem_rdata, rdata_for(cur.addr));
                        chk("d_rdata_zero", d_pmem_rdata, '0);
                    end else begin
                        chk("d_resp", {126'd0, i_pmem_resp, d_pmem_resp}, 128'd1);
                        chk("d_rdata", d_pmem_rdata, rdata_for(cur.addr));
                        chk("i_rdata_zero", i_pmem_rdata, '0);
                    end
                    in_txn = 0;
                    gap = 0;
                end
            end else begin
                gap++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 0; stray_resp = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        chk("reset_outputs", {pmem_address, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, '0);
        chk("reset_rdata", i_pmem_rdata | d_pmem_rdata | pmem_wdata, '0);
        #1 reset_n = 1;

        // Stray resp in IDLE is ignored
        @(negedge clk); #2;
        stray_resp = 1;
        #1 chk("stray_resp", {i_pmem_resp, d_pmem_resp, pmem_read, pmem_write}, '0);
        @(negedge clk); #2;
        stray_resp = 0;
        chk("stray_idle", {pmem_read, pmem_write}, '0);

        // Single I read 0x1230: one-cycle request latency
        push_req(0, 1, 0, 16'h1230, '0, 0);
        exp_push(0, 0, 16'h1230, '0, 0);
        n = 0;
        do begin @(negedge clk); #2; n++; end while (!c_read[0] && n < 20);
        if (n >= 20) timeout("t1_issue");
        chk("lat_before_grant", 128'(pmem_read), 128'd0);
        @(negedge clk); #2;
        chk("lat_after_grant", 128'(pmem_read), 128'd1);
        wait_idle("t1");

        // Tie right after reset: I first, then D write
        @(negedge clk); #3; reset_n = 0;
        @(posedge clk); @(negedge clk); #3; reset_n = 1;
        @(negedge clk); #2;
        push_req(0, 1, 0, 16'h0040, '0, 0);
        push_req(1, 0, 1, 16'h8000, {8{16'h1111}}, 0);
        exp_push(0, 0, 16'h0040, '0, 0);
        exp_push(1, 1, 16'h8000, {8{16'h1111}}, 1);
        wait_idle("t2");

        // Continuous contention: I, D, I, D
        push_req(0, 1, 0, 16'h0100, '0, 0);
        push_req(0, 1, 0, 16'h0102, '0, 0);
        push_req(1, 1, 0, 16'h0200, '0, 0);
        push_req(1, 0, 1, 16'h0202, {8{16'h2222}}, 0);
        exp_push(0, 0, 16'h0100, '0, 0);
        exp_push(1, 0, 16'h0200, '0, 1);
        exp_push(0, 0, 16'h0102, '0, 1);
        exp_push(1, 1, 16'h0202, {8{16'h2222}}, 1);
        wait_idle("t3");

        // D writeback (read+write both high) then fill, I slips in between
        push_req(1, 1, 1, 16'h3000, {8{16'h3333}}, 0);
        push_req(1, 1, 0, 16'h5000, '0, 0);
        exp_push(1, 1, 16'h3000, {8{16'h3333}}, 0);
        exp_push(0, 0, 16'h0100, '0, 1);
        exp_push(1, 0, 16'h5000, '0, 1);
        repeat (2) begin @(negedge clk); #2; end
        push_req(0, 1, 0, 16'h0100, '0, 0);
        wait_idle("t4");

        // Client changes address and drops request mid-transaction
        push_req(0, 1, 0, 16'h1230, '0, 1);
        exp_push(0, 0, 16'h1230, '0, 0);
        wait_idle("t5");

        // Reset mid-SERVE_D: outputs clear immediately, next tie goes to I
        push_req(1, 0, 1, 16'h4000, {8{16'h4444}}, 0);
        exp_push(1, 1, 16'h4000, {8{16'h4444}}, 0);
        n = 0;
        do begin @(negedge clk); #2; n++; end while (!pmem_write && n < 20);
        if (n >= 20) timeout("t6_grant");
        @(negedge clk); #3;
        reset_n = 0;
        #1;
        chk("rst_mid_outputs", {pmem_address, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, '0);
        chk("rst_mid_data", i_pmem_rdata | d_pmem_rdata | pmem_wdata, '0);
        @(posedge clk); @(negedge clk); #3; reset_n = 1;
        @(negedge clk); #2;
        chk("rst_idle", {pmem_read, pmem_write}, '0);
        push_req(0, 1, 0, 16'h0600, '0, 0);
        push_req(1, 1, 0, 16'h0700, '0, 0);
        exp_push(0, 0, 16'h0600, '0, 0);
        exp_push(1, 0, 16'h0700, '0, 1);
        wait_idle("t6");

        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk (input, 1, rising-edge clock) and reset_n (input, 1, async active-low reset).
REQ-002 The block SHALL have the instruction-cache ports i_pmem_read (in, 1), i_pmem_write (in, 1), i_pmem_address (in, lc3b_word), i_pmem_wdata (in, lc3b_c_block, 128), i_pmem_rdata (out, lc3b_c_block) and i_pmem_resp (out, 1).
REQ-003 The block SHALL have the data-cache ports d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata, d_pmem_rdata and d_pmem_resp, with the same directions and widths as REQ-002.
REQ-004 The block SHALL have the physical-memory ports pmem_read (out, 1), pmem_write (out, 1), pmem_address (out, lc3b_word), pmem_wdata (out, lc3b_c_block), pmem_rdata (in, lc3b_c_block) and pmem_resp (in, 1).

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, SERVE_I and SERVE_D.
REQ-006 A client SHALL be treated as requesting when its pmem_read or its pmem_write is high.
REQ-007 In IDLE with exactly one client requesting, the FSM SHALL move on the next edge to that client's SERVE state.
REQ-008 In IDLE with both clients requesting, the FSM SHALL grant the client not recorded in the last_grant flop (round-robin).
REQ-009 On every IDLE-to-SERVE transition, the block SHALL set last_grant to the granted client.
REQ-010 On the granting edge, the block SHALL capture into internal registers the granted client's address, wdata and operation.
REQ-011 If a client drives both read and write high, the captured operation SHALL be write.
REQ-012 In SERVE_x, the block SHALL drive pmem_read or pmem_write (per the captured operation) together with the captured address and wdata, with no combinational dependence on live client inputs.
REQ-013 In SERVE_x, the block SHALL route pmem_rdata to x_pmem_rdata and pmem_resp to x_pmem_resp combinationally, in the same cycle.
REQ-014 The non-granted client's resp SHALL stay 0 at all times.
REQ-015 In SERVE_x with pmem_resp=1, the FSM SHALL return to IDLE on the next edge; with pmem_resp=0 it SHALL remain in SERVE_x.
REQ-016 There SHALL be exactly one IDLE cycle between consecutive memory transactions, so pmem_read/pmem_write deassert for at least one cycle.
REQ-017 Request latency SHALL be 1 cycle: a request present at edge N gives pmem_read/pmem_write high from cycle N+1.
REQ-018 A writeback followed by a fill from the same cache SHALL be two separate grants; the other client MAY be served between them under round-robin.
REQ-019 pmem_resp received in IDLE SHALL be ignored.
REQ-020 A client request that drops mid-transaction SHALL be ignored; the transaction SHALL complete on pmem_resp.
REQ-021 Both rdata outputs SHALL be 0 when their client is not granted.

Reset
REQ-022 Asserting reset_n low SHALL immediately force state=IDLE, last_grant=D (so ICACHE wins the first tie) and clear the captured registers to 0.
REQ-023 While in reset, every output SHALL be 0, including mid-transaction; an in-flight memory response SHALL be dropped.
REQ-024 After reset_n deasserts, the first grant decision SHALL occur on the first rising clk edge.

Structure
REQ-025 lc3b_word and lc3b_c_block SHALL come from lc3b_types.
REQ-026 The arbiter state enum and the grant-id type (ICACHE=0, DCACHE=1) SHALL be added to lc3b_types.
REQ-027 The block SHALL be a single module with no sub-modules; the FSM and the output mux SHALL be separate always blocks.

Verification
REQ-028 I-read only, addr 0x1230, memory responds after 3 cycles with rdata 0xA5..A5 -> pmem_read high for cycles 1-4, pmem_address=0x1230, i_pmem_resp high one cycle with that rdata, d_pmem_resp=0 throughout.
REQ-029 Both request after reset (I read 0x0040, D write 0x8000, wdata 0x1111..1) -> I served first, one IDLE cycle, then D served with pmem_write=1, address 0x8000 and wdata 0x1111..1.
REQ-030 Both request continuously for 4 transactions -> grant order I, D, I, D.
REQ-031 D writeback 0x3000 then D fill 0x5000 while I requests 0x0100 -> order D-wb, I, D-fill, each with correct address.
REQ-032 reset_n pulsed low mid-SERVE_D -> outputs 0 within the same cycle, state IDLE, and the next tie is granted to I.
REQ-033 Client inputs change during SERVE (address 0x1230 -> 0xFFFF) -> pmem_address holds 0x1230 until resp.
